mips_multicycle_sequencer: RTL and testbench

Multi-cycle control FSM for the MIPS datapath. It shares one memory port between instruction fetch and data access. Each instruction is sequenced through IDLE/FETCH/DECODE/EXEC/MEM/WB/BRANCH/JUMP, with per-state control strobes taken from the team opcode map (R=0, beq=1, bne=2, sw=3, lw=4, addi=5, andi=6, ori=7, slti=8, J=9). A memory wait-timeout counter guards the shared bus.

---
 rtl/mips_multicycle_sequencer.sv | 271 +++++++++++++++++++++++++++
 tb/tb_mips_multicycle_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// mips_multicycle_sequencer
//
// Multi-cycle control FSM for the MIPS datapath. One memory port is shared
// between instruction fetch (address from PC) and data access (address from
// the ALU result). Each instruction moves through
// IDLE/FETCH/DECODE/EXEC/MEM/WB/BRANCH/JUMP and the datapath strobes are
// decoded from the state register and the latched opcode (opQ). A wait
// counter bounds every memory access. When it expires, the sticky bus_err
// flag is set and the sequencer parks in IDLE until reset.
//
// Opcode map: R=0, beq=1, bne=2, sw=3, lw=4, addi=5, andi=6, ori=7, slti=8, J=9.
//
// Optional build macro: SEQ_PERF_CNT_EN adds the cyc_cnt and ret_cnt
// performance counters.
//
// Ports:
//   clk, rst_n        clock (rising edge), synchronous active-low reset
//   run               enable instruction sequencing (sampled in IDLE and at retire)
//   opcode            IR[31:26], stable from DECODE onward
//   ir_zero           IR is all zeros (nop)
//   alu_zero          ALU zero flag (branch condition)
//   mem_ready         memory completes the access this cycle
//   mem_req           memory access request
//   mem_sel_data      0 = address from PC, 1 = address from ALU result
//   mem_we            memory write
//   ir_write          load IR
//   pc_write          load PC
//   pc_src            00 = PC+4, 01 = branch target, 10 = jump target
//   alu_src           ALU B operand = immediate
//   alu_op            ALU operation code
//   reg_write         register-file write
//   reg_dst           destination register = rd
//   mem_to_reg        writeback from memory data
//   retire            one-cycle pulse, instruction completed
//   illegal           one-cycle pulse, unknown opcode
//   bus_err           sticky memory-timeout flag
//   state             current state encoding (IDLE=0 ... JUMP=7)
//   cyc_cnt, ret_cnt  non-IDLE cycle count and retire count (SEQ_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module mips_multicycle_sequencer #(
  parameter int OPW    = 6,
  parameter int TO_W   = 4,
  parameter int TO_MAX = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  input  logic           ir_zero,
  input  logic           alu_zero,
  input  logic           mem_ready,
  output logic           mem_req,
  output logic           mem_sel_data,
  output logic           mem_we,
  output logic           ir_write,
  output logic           pc_write,
  output logic [1:0]     pc_src,
  output logic           alu_src,
  output logic [2:0]     alu_op,
  output logic           reg_write,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           retire,
  output logic           illegal,
  output logic           bus_err,
  output logic [2:0]     state
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]    cyc_cnt,
  output logic [31:0]    ret_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    BRANCH = 3'd6,
    JUMP   = 3'd7
  } seqState;

  localparam logic [OPW-1:0] OpR    = OPW'(0);
  localparam logic [OPW-1:0] OpBeq  = OPW'(1);
  localparam logic [OPW-1:0] OpBne  = OPW'(2);
  localparam logic [OPW-1:0] OpSw   = OPW'(3);
  localparam logic [OPW-1:0] OpLw   = OPW'(4);
  localparam logic [OPW-1:0] OpAddi = OPW'(5);
  localparam logic [OPW-1:0] OpAndi = OPW'(6);
  localparam logic [OPW-1:0] OpOri  = OPW'(7);
  localparam logic [OPW-1:0] OpSlti = OPW'(8);
  localparam logic [OPW-1:0] OpJ    = OPW'(9);

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluR   = 3'b010;
  localparam logic [2:0] AluAnd = 3'b011;
  localparam logic [2:0] AluOr  = 3'b100;
  localparam logic [2:0] AluSlt = 3'b111;

  seqState         stateQ, stateD;
  logic [OPW-1:0]  opQ;
  logic [TO_W-1:0] waitCnt;
  logic            busErrQ;
  logic            memPhase;
  logic            timeout;
  seqState         retireTo;

  // ALU control for EXEC and WB; lw/sw use add for the address computation.
  function automatic logic [2:0] execAluOp(input logic [OPW-1:0] op);
    case (op)
      OpR:     execAluOp = AluR;
      OpAndi:  execAluOp = AluAnd;
      OpOri:   execAluOp = AluOr;
      OpSlti:  execAluOp = AluSlt;
      default: execAluOp = AluAdd;
    endcase
  endfunction

  assign memPhase = (stateQ == FETCH) || (stateQ == MEM);
  // The access that is still waiting while the counter sits at TO_MAX is
  // abandoned. A ready on that same cycle still completes normally.
  assign timeout  = memPhase && !mem_ready && (waitCnt == TO_W'(TO_MAX));
  // run is looked at only when an instruction retires, so dropping it
  // mid-instruction never truncates the sequence.
  assign retireTo = run ? FETCH : IDLE;

  // NOTE: every output and stateD gets a default before the case statement,
  // so no path through this block can leave a value held (no latches).
  always_comb begin
    stateD       = stateQ;
    mem_req      = 1'b0;
    mem_sel_data = 1'b0;
    mem_we       = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    alu_src      = 1'b0;
    alu_op       = AluAdd;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    retire       = 1'b0;
    illegal      = 1'b0;

    case (stateQ)
      IDLE: begin
        if (run && !busErrQ) stateD = FETCH;
      end

      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          stateD   = DECODE;
        end else if (timeout) begin
          stateD = IDLE;
        end
      end

      DECODE: begin
        // The opcode input is used directly here. opQ captures it at the
        // end of this cycle for the states that follow.
        if (ir_zero) begin
          retire = 1'b1;
          stateD = retireTo;
        end else begin
          case (opcode)
            OpR, OpSw, OpLw, OpAddi, OpAndi, OpOri, OpSlti: stateD = EXEC;
            OpBeq, OpBne:                                   stateD = BRANCH;
            OpJ:                                            stateD = JUMP;
            default: begin
              illegal = 1'b1;
              stateD  = retireTo;
            end
          endcase
        end
      end

      EXEC: begin
        alu_op  = execAluOp(opQ);
        alu_src = (opQ != OpR);
        stateD  = (opQ == OpLw || opQ == OpSw) ? MEM : WB;
      end

      MEM: begin
        mem_req      = 1'b1;
        mem_sel_data = 1'b1;
        mem_we       = (opQ == OpSw);
        alu_op       = AluAdd;
        alu_src      = 1'b1;
        if (mem_ready) begin
          if (opQ == OpSw) begin
            retire = 1'b1;
            stateD = retireTo;
          end else begin
            stateD = WB;
          end
        end else if (timeout) begin
          stateD = IDLE;
        end
      end

      WB: begin
        reg_write  = 1'b1;
        reg_dst    = (opQ == OpR);
        mem_to_reg = (opQ == OpLw);
        alu_op     = execAluOp(opQ);
        alu_src    = (opQ != OpR);
        retire     = 1'b1;
        stateD     = retireTo;
      end

      BRANCH: begin
        alu_op   = AluSub;
        pc_src   = 2'b01;
        pc_write = ((opQ == OpBeq) && alu_zero) || ((opQ == OpBne) && !alu_zero);
        retire   = 1'b1;
        stateD   = retireTo;
      end

      JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        retire   = 1'b1;
        stateD   = retireTo;
      end

      default: stateD = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments, so every register
  // in this block sees the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ  <= IDLE;
      opQ     <= '0;
      waitCnt <= '0;
      busErrQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      if (stateQ == DECODE) opQ <= opcode;
      if (timeout) busErrQ <= 1'b1;
      // The counter is zero outside FETCH/MEM, so each access starts from 0.
      // It clears again on completion or on timeout.
      if (memPhase && !mem_ready && !timeout) waitCnt <= waitCnt + TO_W'(1);
      else                                    waitCnt <= '0;
    end
  end

  assign bus_err = busErrQ;
  assign state   = stateQ;

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (stateQ != IDLE) cyc_cnt <= cyc_cnt + 32'd1;
      if (retire)         ret_cnt <= ret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_sequencer
//
// Directed bench for mips_multicycle_sequencer. Inputs change on the falling
// edge. All outputs are packed into one control word and compared against
// hand-written expected words 1 ns later, away from the rising edge.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, run, ir_zero, alu_zero, mem_ready;
  logic [5:0] opcode;
  logic       mem_req, mem_sel_data, mem_we, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       alu_src;
  logic [2:0] alu_op;
  logic       reg_write, reg_dst, mem_to_reg, retire, illegal, bus_err;
  logic [2:0] state;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mips_multicycle_sequencer #(.OPW(6), .TO_W(4), .TO_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .ir_zero(ir_zero),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_sel_data(mem_sel_data), .mem_we(mem_we), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src), .alu_op(alu_op),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .retire(retire), .illegal(illegal), .bus_err(bus_err), .state(state)
`ifdef SEQ_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  typedef struct packed {
    logic [2:0] st;
    logic       req, sel, we, irw, pcw;
    logic [1:0] pcs;
    logic       asrc;
    logic [2:0] aop;
    logic       rw, rd, m2r, ret, ill, berr;
  } ctl_t;

  ctl_t obs;
  assign obs = {state, mem_req, mem_sel_data, mem_we, ir_write, pc_write, pc_src,
                alu_src, alu_op, reg_write, reg_dst, mem_to_reg, retire, illegal, bus_err};

  function automatic ctl_t mk(input logic [2:0] st, input logic req, sel, we, irw, pcw,
                              input logic [1:0] pcs, input logic asrc, input logic [2:0] aop,
                              input logic rw, rd, m2r, ret, ill, berr);
    mk = {st, req, sel, we, irw, pcw, pcs, asrc, aop, rw, rd, m2r, ret, ill, berr};
  endfunction

  task automatic check(input string tag, input ctl_t exp);
    #1;
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Expected words shared by many steps.
  function automatic ctl_t eIdle(input logic berr);
    eIdle = mk(3'd0, 0,0,0,0,0, 2'b00, 0, 3'b000, 0,0,0,0,0, berr);
  endfunction
  function automatic ctl_t eFetchDone();
    eFetchDone = mk(3'd1, 1,0,0,1,1, 2'b00, 0, 3'b000, 0,0,0,0,0,0);
  endfunction
  function automatic ctl_t eFetchWait();
    eFetchWait = mk(3'd1, 1,0,0,0,0, 2'b00, 0, 3'b000, 0,0,0,0,0,0);
  endfunction
  function automatic ctl_t eDecode(input logic ret, ill);
    eDecode = mk(3'd2, 0,0,0,0,0, 2'b00, 0, 3'b000, 0,0,0, ret, ill, 0);
  endfunction

  // FETCH -> DECODE -> EXEC -> WB for a register/immediate ALU instruction.
  // Entered at a FETCH cycle with run=1 and mem_ready=1; returns at the next FETCH.
  task automatic runAlu(input string name, input logic [5:0] op, input logic [2:0] aop,
                        input logic asrc, input logic rd);
    opcode = op;
    check({name, "_fetch"}, eFetchDone());
    nxt();
    check({name, "_decode"}, eDecode(0, 0));
    nxt();
    check({name, "_exec"}, mk(3'd3, 0,0,0,0,0, 2'b00, asrc, aop, 0,0,0,0,0,0));
    nxt();
    check({name, "_wb"}, mk(3'd5, 0,0,0,0,0, 2'b00, asrc, aop, 1, rd, 0, 1, 0, 0));
    nxt();
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; ir_zero = 1'b0; alu_zero = 1'b0;
    mem_ready = 1'b0; opcode = 6'd0;

    // Reset state, then start a lw and pull reset while it waits in MEM.
    nxt();
    check("reset_idle", eIdle(0));
    rst_n = 1'b1; run = 1'b1; opcode = 6'd4; mem_ready = 1'b1;
    nxt();
    check("lwA_fetch", eFetchDone());
    nxt();
    check("lwA_decode", eDecode(0, 0));
    nxt();
    check("lwA_exec", mk(3'd3, 0,0,0,0,0, 2'b00, 1, 3'b000, 0,0,0,0,0,0));
    nxt();
    mem_ready = 1'b0;
    check("lwA_mem_wait", mk(3'd4, 1,1,0,0,0, 2'b00, 1, 3'b000, 0,0,0,0,0,0));
    rst_n = 1'b0;
    nxt();
    check("rst_cycle1", eIdle(0));
    nxt();
    check("rst_cycle2", eIdle(0));
    rst_n = 1'b1; run = 1'b0; mem_ready = 1'b1;
    nxt();
    check("idle_run0_a", eIdle(0));
    nxt();
    check("idle_run0_b", eIdle(0));

    // addi: FETCH, DECODE, EXEC, WB.
    run = 1'b1;
    nxt();
    runAlu("addi", 6'd5, 3'b000, 1'b1, 1'b0);

    // lw with three wait cycles in MEM.
    opcode = 6'd4;
    check("lw_fetch", eFetchDone());
    nxt();
    check("lw_decode", eDecode(0, 0));
    nxt();
    check("lw_exec", mk(3'd3, 0,0,0,0,0, 2'b00, 1, 3'b000, 0,0,0,0,0,0));
    nxt();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("lw_mem_wait%0d", i), mk(3'd4, 1,1,0,0,0, 2'b00, 1, 3'b000, 0,0,0,0,0,0));
      nxt();
    end
    mem_ready = 1'b1;
    check("lw_mem_done", mk(3'd4, 1,1,0,0,0, 2'b00, 1, 3'b000, 0,0,0,0,0,0));
    nxt();
    check("lw_wb", mk(3'd5, 0,0,0,0,0, 2'b00, 1, 3'b000, 1,0,1,1,0,0));
    nxt();

    // sw with one wait cycle; it retires from MEM.
    opcode = 6'd3;
    check("sw_fetch", eFetchDone());
    nxt();
    check("sw_decode", eDecode(0, 0));
    nxt();
    check("sw_exec", mk(3'd3, 0,0,0,0,0, 2'b00, 1, 3'b000, 0,0,0,0,0,0));
    nxt();
    mem_ready = 1'b0;
    check("sw_mem_wait", mk(3'd4, 1,1,1,0,0, 2'b00, 1, 3'b000, 0,0,0,0,0,0));
    nxt();
    mem_ready = 1'b1;
    check("sw_mem_done", mk(3'd4, 1,1,1,0,0, 2'b00, 1, 3'b000, 0,0,0,1,0,0));
    nxt();

    // R-type and the remaining ALU-immediate encodings.
    runAlu("rtype", 6'd0, 3'b010, 1'b0, 1'b1);
    runAlu("andi",  6'd6, 3'b011, 1'b1, 1'b0);
    runAlu("ori",   6'd7, 3'b100, 1'b1, 1'b0);
    runAlu("slti",  6'd8, 3'b111, 1'b1, 1'b0);

    // beq: taken when alu_zero=1, not taken when alu_zero=0.
    opcode = 6'd1; alu_zero = 1'b1;
    check("beq_fetch", eFetchDone());
    nxt();
    check("beq_decode", eDecode(0, 0));
    nxt();
    check("beq_z1", mk(3'd6, 0,0,0,0,1, 2'b01, 0, 3'b001, 0,0,0,1,0,0));
    alu_zero = 1'b0;
    check("beq_z0", mk(3'd6, 0,0,0,0,0, 2'b01, 0, 3'b001, 0,0,0,1,0,0));
    nxt();

    // bne: the opposite sense.
    opcode = 6'd2; alu_zero = 1'b1;
    check("bne_fetch", eFetchDone());
    nxt();
    check("bne_decode", eDecode(0, 0));
    nxt();
    check("bne_z1", mk(3'd6, 0,0,0,0,0, 2'b01, 0, 3'b001, 0,0,0,1,0,0));
    alu_zero = 1'b0;
    check("bne_z0", mk(3'd6, 0,0,0,0,1, 2'b01, 0, 3'b001, 0,0,0,1,0,0));
    nxt();

    // Jump.
    opcode = 6'd9;
    check("j_fetch", eFetchDone());
    nxt();
    check("j_decode", eDecode(0, 0));
    nxt();
    check("j_jump", mk(3'd7, 0,0,0,0,1, 2'b10, 0, 3'b000, 0,0,0,1,0,0));
    nxt();

    // Illegal opcode, then a nop with run dropped so the nop parks in IDLE.
    opcode = 6'h3F;
    check("ill_fetch", eFetchDone());
    nxt();
    check("ill_decode", eDecode(0, 1));
    nxt();
    opcode = 6'd0; ir_zero = 1'b1;
    check("nop_fetch", eFetchDone());
    nxt();
    run = 1'b0;
    check("nop_decode", eDecode(1, 0));
    nxt();
    check("nop_to_idle", eIdle(0));

    // Ready arriving on the last tolerated wait cycle completes normally.
    run = 1'b1; ir_zero = 1'b0; mem_ready = 1'b0;
    nxt();
    for (int i = 0; i < 15; i++) begin
      check($sformatf("edge_wait%0d", i), eFetchWait());
      nxt();
    end
    mem_ready = 1'b1;
    check("edge_ready_last", eFetchDone());
    nxt();
    ir_zero = 1'b1;
    check("edge_decode_nop", eDecode(1, 0));
    nxt();

    // Timeout: 16 request cycles, then bus_err and IDLE, and run is ignored.
    ir_zero = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("to_wait%0d", i), eFetchWait());
      nxt();
    end
    check("to_bus_err", eIdle(1));
    nxt();
    check("to_ignore_run_a", eIdle(1));
    nxt();
    check("to_ignore_run_b", eIdle(1));

    // Only reset clears bus_err; sequencing resumes afterwards.
    rst_n = 1'b0;
    nxt();
    check("to_reset_clear", eIdle(0));
    rst_n = 1'b1; mem_ready = 1'b1;
    nxt();
    check("post_reset_fetch", eFetchDone());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
